// File: rtl/cotm32_pkg.sv
// rtl/cotm32_pkg.sv - core-wide architectural parameters
package cotm32_pkg;
    localparam int MXLEN = 32;
endpackage

// File: rtl/cotm32_priv_pkg.sv
// rtl/cotm32_priv_pkg.sv - machine-mode privileged types, cause codes and MIE bit indices
package cotm32_priv_pkg;
    localparam int CODE_W = cotm32_pkg::MXLEN - 1;

    typedef struct packed {
        logic              interrupt;
        logic [CODE_W-1:0] code;
    } trap_cause_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTER  = 2'd1,
        VECTOR = 2'd2,
        RET    = 2'd3
    } trap_state_t;

    typedef enum logic {
        TVAL_ZERO = 1'b0,
        TVAL_EXC  = 1'b1
    } tval_sel_t;

    localparam logic [CODE_W-1:0] EXC_IAM     = CODE_W'(0);
    localparam logic [CODE_W-1:0] EXC_ILL     = CODE_W'(2);
    localparam logic [CODE_W-1:0] EXC_BRK     = CODE_W'(3);
    localparam logic [CODE_W-1:0] EXC_LAM     = CODE_W'(4);
    localparam logic [CODE_W-1:0] EXC_SAM     = CODE_W'(6);
    localparam logic [CODE_W-1:0] EXC_ECALL_M = CODE_W'(11);
    localparam logic [CODE_W-1:0] IRQ_MSI     = CODE_W'(3);
    localparam logic [CODE_W-1:0] IRQ_MTI     = CODE_W'(7);
    localparam logic [CODE_W-1:0] IRQ_MEI     = CODE_W'(11);

    localparam int MIE_MSIE = 3;
    localparam int MIE_MTIE = 7;
    localparam int MIE_MEIE = 11;

    function automatic trap_cause_t mk_cause(input logic intr, input logic [CODE_W-1:0] code);
        trap_cause_t c;
        c.interrupt = intr;
        c.code      = code;
        return c;
    endfunction
endpackage

// File: rtl/trap_prio_enc.sv
// rtl/trap_prio_enc.sv - combinational priority encoder from interrupt lines and exception flags to a trap cause
module trap_prio_enc
    import cotm32_priv_pkg::*;
(
    input  logic        exc_iam,
    input  logic        exc_ill,
    input  logic        exc_ebreak,
    input  logic        exc_ecall,
    input  logic        exc_lam,
    input  logic        exc_sam,
    input  logic        irq_ext,
    input  logic        irq_sw,
    input  logic        irq_tmr,
    input  logic        mstatus_mie,
    input  logic        mie_meie,
    input  logic        mie_msie,
    input  logic        mie_mtie,
    output logic        valid,
    output trap_cause_t cause,
    output tval_sel_t   tval_sel
);
    logic ext_en;
    logic sw_en;
    logic tmr_en;

    assign ext_en = mstatus_mie & irq_ext & mie_meie;
    assign sw_en  = mstatus_mie & irq_sw  & mie_msie;
    assign tmr_en = mstatus_mie & irq_tmr & mie_mtie;

    // Interrupts outrank every exception; the boundary instruction is simply discarded.
    always_comb begin
        valid    = 1'b1;
        cause    = mk_cause(1'b0, EXC_IAM);
        tval_sel = TVAL_ZERO;
        if (ext_en) begin
            cause = mk_cause(1'b1, IRQ_MEI);
        end else if (sw_en) begin
            cause = mk_cause(1'b1, IRQ_MSI);
        end else if (tmr_en) begin
            cause = mk_cause(1'b1, IRQ_MTI);
        end else if (exc_iam) begin
            cause    = mk_cause(1'b0, EXC_IAM);
            tval_sel = TVAL_EXC;
        end else if (exc_ill) begin
            cause    = mk_cause(1'b0, EXC_ILL);
            tval_sel = TVAL_EXC;
        end else if (exc_ebreak) begin
            cause = mk_cause(1'b0, EXC_BRK);
        end else if (exc_ecall) begin
            cause = mk_cause(1'b0, EXC_ECALL_M);
        end else if (exc_lam) begin
            cause    = mk_cause(1'b0, EXC_LAM);
            tval_sel = TVAL_EXC;
        end else if (exc_sam) begin
            cause    = mk_cause(1'b0, EXC_SAM);
            tval_sel = TVAL_EXC;
        end else begin
            valid = 1'b0;
        end
    end
endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap entry / mret sequencer at the retirement boundary
module trap_ctrl
    import cotm32_priv_pkg::*;
#(
    parameter int MXLEN = cotm32_pkg::MXLEN
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_instr_valid,
    input  logic [MXLEN-1:0] i_pc,
    input  logic             i_exc_iam,
    input  logic             i_exc_ill,
    input  logic             i_exc_ebreak,
    input  logic             i_exc_ecall,
    input  logic             i_exc_lam,
    input  logic             i_exc_sam,
    input  logic [MXLEN-1:0] i_exc_tval,
    input  logic             i_mret,
    input  logic             i_irq_ext,
    input  logic             i_irq_sw,
    input  logic             i_irq_tmr,
    input  logic             i_mstatus_mie,
    input  logic [MXLEN-1:0] i_mie,
    input  logic [MXLEN-1:0] i_mtvec,
    input  logic [MXLEN-1:0] i_mepc,
    output logic             o_trap_req,
    output trap_cause_t      o_trap_cause,
    output logic [MXLEN-1:0] o_trap_tval,
    output logic [MXLEN-1:0] o_trap_pc,
    output logic             o_mret_req,
    output logic             o_redirect,
    output logic [MXLEN-1:0] o_redirect_pc,
    output logic             o_stall
);
    trap_state_t      state;
    trap_state_t      state_nxt;
    logic             enc_valid;
    trap_cause_t      enc_cause;
    tval_sel_t        enc_tval_sel;
    trap_cause_t      cause_q;
    logic [MXLEN-1:0] tval_q;
    logic [MXLEN-1:0] epc_q;
    logic             take_trap;
    logic [MXLEN-1:0] mtvec_base;
    logic [MXLEN-1:0] code_ext;
    logic [MXLEN-1:0] vec_target;
    logic             unused_bits;

    trap_prio_enc u_prio (
        .exc_iam     (i_exc_iam),
        .exc_ill     (i_exc_ill),
        .exc_ebreak  (i_exc_ebreak),
        .exc_ecall   (i_exc_ecall),
        .exc_lam     (i_exc_lam),
        .exc_sam     (i_exc_sam),
        .irq_ext     (i_irq_ext),
        .irq_sw      (i_irq_sw),
        .irq_tmr     (i_irq_tmr),
        .mstatus_mie (i_mstatus_mie),
        .mie_meie    (i_mie[MIE_MEIE]),
        .mie_msie    (i_mie[MIE_MSIE]),
        .mie_mtie    (i_mie[MIE_MTIE]),
        .valid       (enc_valid),
        .cause       (enc_cause),
        .tval_sel    (enc_tval_sel)
    );

    assign take_trap = (state == IDLE) && i_instr_valid && enc_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_instr_valid) begin
                    if (enc_valid) begin
                        state_nxt = ENTER;
                    end else if (i_mret) begin
                        state_nxt = RET;
                    end
                end
            end
            ENTER:   state_nxt = VECTOR;
            VECTOR:  state_nxt = IDLE;
            RET:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Captured once on the IDLE exit so the CSR write sees a stable cause/tval/epc.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cause_q <= '0;
            tval_q  <= '0;
            epc_q   <= '0;
        end else if (take_trap) begin
            cause_q <= enc_cause;
            tval_q  <= (enc_tval_sel == TVAL_EXC) ? i_exc_tval : '0;
            epc_q   <= i_pc;
        end
    end

    assign mtvec_base = {i_mtvec[MXLEN-1:2], 2'b00};
    assign code_ext   = MXLEN'(cause_q.code);
    // Only mode 1 vectors, and only for interrupts; modes 2/3 fall back to direct.
    assign vec_target = ((i_mtvec[1:0] == 2'b01) && cause_q.interrupt)
                      ? mtvec_base + (code_ext << 2)
                      : mtvec_base;

    always_comb begin
        o_trap_req    = 1'b0;
        o_mret_req    = 1'b0;
        o_redirect    = 1'b0;
        o_redirect_pc = '0;
        o_stall       = (state != IDLE);
        case (state)
            ENTER: o_trap_req = 1'b1;
            VECTOR: begin
                o_redirect    = 1'b1;
                o_redirect_pc = vec_target;
            end
            RET: begin
                o_mret_req    = 1'b1;
                o_redirect    = 1'b1;
                o_redirect_pc = {i_mepc[MXLEN-1:2], 2'b00};
            end
            default: ;
        endcase
    end

    assign o_trap_cause = cause_q;
    assign o_trap_tval  = tval_q;
    assign o_trap_pc    = epc_q;

    assign unused_bits = ^{i_mie[MXLEN-1:MIE_MEIE+1], i_mie[MIE_MEIE-1:MIE_MTIE+1],
                           i_mie[MIE_MTIE-1:MIE_MSIE+1], i_mie[MIE_MSIE-1:0], i_mepc[1:0]};
endmodule
